// File: rtl/instruction_memory.sv
// Word-organised MIPS instruction memory: registered 32-bit read, fixed program image reloaded on reset.
// Define INSTR_MEM_WRITE_EN to add a synchronous write port (read-before-write on same-word collisions).
module instruction_memory #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] read_address,
`ifdef INSTR_MEM_WRITE_EN
  input  logic        wr_en,
  input  logic [31:0] wr_address,
  input  logic [31:0] wr_data,
`endif
  output logic [31:0] inst
);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] rd_index;
  logic              rd_in_range;

  // Built-in program image; everything past word 11 is a NOP.
  function automatic logic [31:0] default_word(input int unsigned idx);
    logic [31:0] w;
    w = '0;
    case (idx)
      0:  w = 32'h2001_0005;
      1:  w = 32'h2002_000A;
      2:  w = 32'h0022_1820;
      3:  w = 32'h0062_2022;
      4:  w = 32'h0022_2824;
      5:  w = 32'h0022_3025;
      6:  w = 32'h0022_382A;
      7:  w = 32'hAC03_0004;
      8:  w = 32'h8C08_0004;
      9:  w = 32'h1103_0001;
      10: w = 32'h0000_0000;
      11: w = 32'h0800_0000;
      default: w = '0;
    endcase
    return w;
  endfunction

  always_comb begin
    rd_index    = read_address[ADDR_W+1:2];
    rd_in_range = (read_address[31:ADDR_W+2] == '0);
  end

`ifdef INSTR_MEM_WRITE_EN
  logic [ADDR_W-1:0] wr_index;
  logic              wr_in_range;

  always_comb begin
    wr_index    = wr_address[ADDR_W+1:2];
    wr_in_range = (wr_address[31:ADDR_W+2] == '0);
  end
`endif

  // Read and write share one block so reset can restore the image;
  // the nonblocking read of mem gives read-before-write ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= default_word(i);
      end
    end else begin
      inst <= rd_in_range ? mem[rd_index] : '0;
`ifdef INSTR_MEM_WRITE_EN
      if (wr_en && wr_in_range) begin
        mem[wr_index] <= wr_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Bench for instruction_memory: directed boundary steps plus random reads (and writes when
// INSTR_MEM_WRITE_EN is defined) checked against an array-based reference model.
module tb_instruction_memory;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] read_address;
  logic [31:0] inst;
`ifdef INSTR_MEM_WRITE_EN
  logic        wr_en;
  logic [31:0] wr_address;
  logic [31:0] wr_data;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] golden [DEPTH];
  logic [31:0] model  [DEPTH];

  instruction_memory #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .read_address (read_address),
`ifdef INSTR_MEM_WRITE_EN
    .wr_en        (wr_en),
    .wr_address   (wr_address),
    .wr_data      (wr_data),
`endif
    .inst         (inst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] exp);
    total++;
    assert (inst === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, inst, exp);
    end
  endtask

  // Byte address -> word; anything at or beyond DEPTH*4 bytes reads as NOP.
  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (a >= 32'(DEPTH * 4)) return '0;
    return model[a / 4];
  endfunction

  task automatic restore_model();
    for (int i = 0; i < DEPTH; i++) model[i] = golden[i];
  endtask

  task automatic read_step(input string tag, input logic [31:0] addr);
    logic [31:0] exp;
    read_address = addr;
    exp = ref_read(addr);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

`ifdef INSTR_MEM_WRITE_EN
  task automatic rw_step(input string tag, input logic [31:0] addr, input logic we,
                         input logic [31:0] waddr, input logic [31:0] wdata);
    logic [31:0] exp;
    read_address = addr;
    wr_en        = we;
    wr_address   = waddr;
    wr_data      = wdata;
    exp = ref_read(addr);
    if (we && waddr < 32'(DEPTH * 4)) model[waddr / 4] = wdata;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    check(tag, exp);
  endtask
`endif

  initial begin
    logic [31:0] addr;
    for (int i = 0; i < DEPTH; i++) golden[i] = '0;
    golden[0]  = 32'h2001_0005;
    golden[1]  = 32'h2002_000A;
    golden[2]  = 32'h0022_1820;
    golden[3]  = 32'h0062_2022;
    golden[4]  = 32'h0022_2824;
    golden[5]  = 32'h0022_3025;
    golden[6]  = 32'h0022_382A;
    golden[7]  = 32'hAC03_0004;
    golden[8]  = 32'h8C08_0004;
    golden[9]  = 32'h1103_0001;
    golden[10] = 32'h0000_0000;
    golden[11] = 32'h0800_0000;
    restore_model();

    rst          = 1'b1;
    read_address = '0;
`ifdef INSTR_MEM_WRITE_EN
    wr_en      = 1'b0;
    wr_address = '0;
    wr_data    = '0;
`endif

    // Reset held with clock running
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", 32'h0);
    end

    rst = 1'b0;
    read_step("first_read", 32'd0);
    read_step("addr_32", 32'd32);
    read_step("misalign_33", 32'd33);
    read_step("misalign_35", 32'd35);
    read_step("addr_44", 32'd44);
    read_step("addr_48", 32'd48);
    read_step("last_word", 32'd252);
    read_step("oor_256", 32'd256);
    read_step("oor_high", 32'h8000_0000);

    // Asynchronous reset between edges
    read_step("pre_async", 32'd32);
    #2 rst = 1'b1;
    #1 check("async_rst", 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_edge", 32'h0);
    rst = 1'b0;
    restore_model();
    read_step("after_rst", 32'd32);

`ifdef INSTR_MEM_WRITE_EN
    rw_step("wr_collide_old", 32'd40, 1'b1, 32'd40, 32'hDEAD_BEEF);
    read_step("wr_readback", 32'd40);
    rw_step("wr_oor_ignored", 32'd0, 1'b1, 32'd256, 32'h1234_5678);
    read_step("oor_after_wr", 32'd0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    restore_model();
    read_step("wr_cleared", 32'd40);
`endif

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) addr = $urandom();
      else addr = $urandom_range(0, DEPTH * 4 + 15);
`ifdef INSTR_MEM_WRITE_EN
      if ($urandom_range(0, 2) == 0) begin
        logic [31:0] wa;
        wa = (addr[0] && $urandom_range(0, 1) == 1) ? addr : $urandom_range(0, DEPTH * 4 + 31);
        rw_step("rand_rw", addr, 1'b1, wa, $urandom());
      end else begin
        read_step("rand_read", addr);
      end
`else
      read_step("rand_read", addr);
`endif
      if (n == 200) begin
        #2 rst = 1'b1;
        #1 check("rand_async_rst", 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        restore_model();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
